npu_config_sequencer: RTL and testbench
=======================================

# npu_config_sequencer

Decodes the NPU configuration word stream from the config FIFO and routes each word to its destination. Destinations are the NPU state machine's input/output count registers and the processing-engine weight memory. It sits between the config FIFO (first-word-fall-through) and the NPU state machine. It pops words only while the state machine is in its config state, and it keeps its packet position across config-state exits so that split packets resume correctly.

## Interface
- AW, 8, weight memory address width; weight capacity is 2^AW words
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- npu_state_config  in  1  state machine config-state flag
- npu_config_fifo_empty  in  1  config FIFO empty
- npu_config_fifo_dout  in  16  config FIFO head word (FWFT, valid when not empty)
- npu_config_fifo_read_en  out  1  pop strobe, combinational
- npu_state_data_in  out  16  count value to the state machine, registered
- npu_state_input_reg_enable  out  1  load input count, registered one-cycle pulse
- npu_state_output_reg_enable  out  1  load output count, registered one-cycle pulse
- weight_wr_en  out  1  weight memory write strobe, registered
- weight_wr_addr  out  AW  weight write address, registered
- weight_wr_data  out  16  weight write data, registered
- config_done  out  1  one-cycle pulse when a packet completes
- config_error  out  1  sticky weight-overflow flag

## Operation
- Packet format: word0 = input count, word1 = output count, word2 = weight count N (16-bit unsigned), then N weight words.
- Packets repeat back to back.
- Pop condition: npu_config_fifo_read_en = npu_state_config && ~npu_config_fifo_empty. There is no other gating; every popped word is consumed.
- Phases: S_IN → S_OUT → S_WCNT → S_WGT → S_IN.
  - S_IN, on pop: data_in <= dout; input_reg_enable <= 1; go to S_OUT.
  - S_OUT, on pop: data_in <= dout; output_reg_enable <= 1; go to S_WCNT.
  - S_WCNT, on pop: remaining <= dout; addr counter <= 0. If dout == 0, go to S_IN and pulse config_done. Otherwise go to S_WGT.
  - S_WGT, on pop:
    - If addr counter < 2^AW: weight_wr_en <= 1, weight_wr_addr <= addr counter, weight_wr_data <= dout.
    - Otherwise: discard the word and set config_error <= 1.
    - Then remaining--, and addr counter increments (saturating one past 2^AW-1).
    - When remaining == 1 at the pop: go to S_IN and pulse config_done.
- Without a pop, the phase, remaining count and address hold. All strobes deassert the next cycle.
- Deasserting npu_state_config mid-packet freezes the sequencer. It resumes at the same phase when config is re-entered. It never re-synchronises on its own; only RST does.
- Counters are 16 bits. The address counter is AW+1 bits so that overflow is detectable without wrap-around.
- Reset values:
  - phase S_IN; remaining 0; addr counter 0
  - all strobes 0; data_in 0; weight_wr_addr 0; weight_wr_data 0
  - config_done 0; config_error 0
- RST mid-packet discards all packet progress. FIFO contents are not flushed.

## Timing
- Pop to register strobe: 1 cycle. A strobe is high in the cycle after the pop, with data_in/weight data valid in the same cycle.
- When the last word is popped at cycle t, the state machine still has config=1 at cycle t+1. Its load at the end of t+1 therefore captures the count before it returns to idle.
- Throughput: one word per cycle while the FIFO is non-empty.
- config_done is asserted in the cycle after the final pop of a packet, coincident with the last strobe.

## Test plan
- Basic packet: FIFO holds 10, 3, 2, 0xAAAA, 0x5555 with config=1.
  - Expect input_reg_enable with data 10, then output_reg_enable with data 3.
  - Expect weight writes addr0 = 0xAAAA and addr1 = 0x5555.
  - Expect config_done in the same cycle as the addr1 write, on 5 consecutive cycles.
- Zero weights: words 4, 1, 0.
  - Expect no weight_wr_en and config_done one cycle after the third pop.
  - A following packet 7, 2, 0 decodes normally.
- Split packet: push 4, 1; config=1 until empty; drop config for 5 cycles; push 1, 0x1234; raise config.
  - Expect a weight-count pop, then a single write addr0 = 0x1234, then config_done.
  - No strobes while config=0.
- Overflow with AW=2: count 6, weights 1..6.
  - Expect writes to addr0..3 with values 1..4, and words 5 and 6 popped but not written.
  - config_error rises the cycle after the 5th weight pop and stays high.
- Stall gating: FIFO non-empty while config=0 → read_en stays 0 and nothing changes.
- Reset mid-packet: RST after popping 9, 2.
  - All outputs return to reset values.
  - The next words 8, 1, 0 are decoded as a fresh packet (input count 8).

Source files
------------

// File: rtl/npu_config_sequencer.sv
// Config word stream decoder: routes FIFO words to the NPU state machine count
// registers and the weight memory, keeping packet position across config exits.
module npu_config_sequencer #(
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          npu_state_config,
    input  logic          npu_config_fifo_empty,
    input  logic [15:0]   npu_config_fifo_dout,
    output logic          npu_config_fifo_read_en,
    output logic [15:0]   npu_state_data_in,
    output logic          npu_state_input_reg_enable,
    output logic          npu_state_output_reg_enable,
    output logic          weight_wr_en,
    output logic [AW-1:0] weight_wr_addr,
    output logic [15:0]   weight_wr_data,
    output logic          config_done,
    output logic          config_error
);

    typedef enum logic [1:0] {S_IN, S_OUT, S_WCNT, S_WGT} phase_t;

    phase_t        phase, phase_n;
    logic [15:0]   remaining, remaining_n;
    logic [AW:0]   addr, addr_n;
    logic [15:0]   data_in_n, wr_data_n;
    logic [AW-1:0] wr_addr_n;
    logic          in_en_n, out_en_n, wr_en_n, done_n, error_n;
    logic          pop;

    assign pop = npu_state_config && !npu_config_fifo_empty;
    assign npu_config_fifo_read_en = pop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase                       <= S_IN;
            remaining                   <= '0;
            addr                        <= '0;
            npu_state_data_in           <= '0;
            npu_state_input_reg_enable  <= 1'b0;
            npu_state_output_reg_enable <= 1'b0;
            weight_wr_en                <= 1'b0;
            weight_wr_addr              <= '0;
            weight_wr_data              <= '0;
            config_done                 <= 1'b0;
            config_error                <= 1'b0;
        end else begin
            phase                       <= phase_n;
            remaining                   <= remaining_n;
            addr                        <= addr_n;
            npu_state_data_in           <= data_in_n;
            npu_state_input_reg_enable  <= in_en_n;
            npu_state_output_reg_enable <= out_en_n;
            weight_wr_en                <= wr_en_n;
            weight_wr_addr              <= wr_addr_n;
            weight_wr_data              <= wr_data_n;
            config_done                 <= done_n;
            config_error                <= error_n;
        end
    end

    always_comb begin
        phase_n     = phase;
        remaining_n = remaining;
        addr_n      = addr;
        data_in_n   = npu_state_data_in;
        wr_addr_n   = weight_wr_addr;
        wr_data_n   = weight_wr_data;
        in_en_n     = 1'b0;
        out_en_n    = 1'b0;
        wr_en_n     = 1'b0;
        done_n      = 1'b0;
        error_n     = config_error;
        if (pop) begin
            unique case (phase)
                S_IN: begin
                    data_in_n = npu_config_fifo_dout;
                    in_en_n   = 1'b1;
                    phase_n   = S_OUT;
                end
                S_OUT: begin
                    data_in_n = npu_config_fifo_dout;
                    out_en_n  = 1'b1;
                    phase_n   = S_WCNT;
                end
                S_WCNT: begin
                    remaining_n = npu_config_fifo_dout;
                    addr_n      = '0;
                    if (npu_config_fifo_dout == 16'd0) begin
                        done_n  = 1'b1;
                        phase_n = S_IN;
                    end else begin
                        phase_n = S_WGT;
                    end
                end
                S_WGT: begin
                    // addr saturates at 2^AW, so its MSB alone flags overflow
                    if (!addr[AW]) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = addr[AW-1:0];
                        wr_data_n = npu_config_fifo_dout;
                        addr_n    = addr + 1'b1;
                    end else begin
                        error_n = 1'b1;
                    end
                    remaining_n = remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        done_n  = 1'b1;
                        phase_n = S_IN;
                    end
                end
                default: phase_n = S_IN;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_config_sequencer.sv
// Self-checking bench: constant vector table, directed corner sequences, and
// randomized packet streams against a position-based packet model.
module tb_npu_config_sequencer;

    localparam int AW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          npu_state_config = 1'b0;
    logic          npu_config_fifo_empty = 1'b1;
    logic [15:0]   npu_config_fifo_dout = '0;
    logic          npu_config_fifo_read_en;
    logic [15:0]   npu_state_data_in;
    logic          npu_state_input_reg_enable;
    logic          npu_state_output_reg_enable;
    logic          weight_wr_en;
    logic [AW-1:0] weight_wr_addr;
    logic [15:0]   weight_wr_data;
    logic          config_done;
    logic          config_error;

    npu_config_sequencer #(.AW(AW)) dut (
        .CLK(CLK),
        .RST(RST),
        .npu_state_config(npu_state_config),
        .npu_config_fifo_empty(npu_config_fifo_empty),
        .npu_config_fifo_dout(npu_config_fifo_dout),
        .npu_config_fifo_read_en(npu_config_fifo_read_en),
        .npu_state_data_in(npu_state_data_in),
        .npu_state_input_reg_enable(npu_state_input_reg_enable),
        .npu_state_output_reg_enable(npu_state_output_reg_enable),
        .weight_wr_en(weight_wr_en),
        .weight_wr_addr(weight_wr_addr),
        .weight_wr_data(weight_wr_data),
        .config_done(config_done),
        .config_error(config_error)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: packet position index rather than phase/counters
    int          m_pos, m_wcnt;
    logic        e_in, e_out, e_wr, e_done, e_err;
    logic [15:0] e_data_in, e_wr_data;
    logic [AW-1:0] e_wr_addr;
    logic [15:0] fifo[$];
    logic [15:0] pending[$];

    typedef struct {
        logic        cfg;
        logic        has;
        logic [15:0] dout;
        logic        rd;
        logic        in_en;
        logic        out_en;
        logic [15:0] data_in;
        logic        wr_en;
        logic [AW-1:0] wr_addr;
        logic [15:0] wr_data;
        logic        done;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return {npu_state_input_reg_enable, npu_state_output_reg_enable, npu_state_data_in,
                weight_wr_en, weight_wr_addr, weight_wr_data, config_done, config_error};
    endfunction

    function automatic logic [63:0] pack(input logic in_en, out_en, input logic [15:0] d,
                                         input logic wr, input logic [AW-1:0] a,
                                         input logic [15:0] wd, input logic dn, er);
        return {in_en, out_en, d, wr, a, wd, dn, er};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_wcnt = 0;
        e_in = 0; e_out = 0; e_wr = 0; e_done = 0; e_err = 0;
        e_data_in = '0; e_wr_data = '0; e_wr_addr = '0;
    endtask

    task automatic model_word(input logic [15:0] w);
        int k;
        if (m_pos == 0) begin
            e_data_in = w; e_in = 1; m_pos = 1;
        end else if (m_pos == 1) begin
            e_data_in = w; e_out = 1; m_pos = 2;
        end else if (m_pos == 2) begin
            m_wcnt = int'(w);
            if (w == 0) begin e_done = 1; m_pos = 0; end
            else m_pos = 3;
        end else begin
            k = m_pos - 3;
            if (k < (1 << AW)) begin
                e_wr = 1; e_wr_addr = k[AW-1:0]; e_wr_data = w;
            end else begin
                e_err = 1;
            end
            if (k == m_wcnt - 1) begin e_done = 1; m_pos = 0; end
            else m_pos++;
        end
    endtask

    task automatic check_model(input string name);
        chk(name, outs(), pack(e_in, e_out, e_data_in, e_wr, e_wr_addr, e_wr_data, e_done, e_err));
    endtask

    task automatic step(input logic cfg);
        logic pop;
        npu_state_config = cfg;
        npu_config_fifo_empty = (fifo.size() == 0);
        npu_config_fifo_dout = (fifo.size() != 0) ? fifo[0] : 16'($urandom);
        pop = cfg && (fifo.size() != 0);
        #1;
        chk("read_en", {63'd0, npu_config_fifo_read_en}, {63'd0, pop});
        @(posedge CLK);
        e_in = 0; e_out = 0; e_wr = 0; e_done = 0;
        if (pop) model_word(fifo.pop_front());
        #1;
        check_model("outputs");
    endtask

    task automatic do_reset();
        RST = 1'b1;
        npu_state_config = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        check_model("reset_state");
    endtask

    initial begin
        vec_t tbl[14];
        tbl[0]  = '{1,1,16'd10,   1, 1,0,16'd10, 0,2'd0,16'h0000, 0,0};
        tbl[1]  = '{1,1,16'd3,    1, 0,1,16'd3,  0,2'd0,16'h0000, 0,0};
        tbl[2]  = '{1,1,16'd2,    1, 0,0,16'd3,  0,2'd0,16'h0000, 0,0};
        tbl[3]  = '{1,1,16'hAAAA, 1, 0,0,16'd3,  1,2'd0,16'hAAAA, 0,0};
        tbl[4]  = '{1,1,16'h5555, 1, 0,0,16'd3,  1,2'd1,16'h5555, 1,0};
        tbl[5]  = '{1,1,16'd4,    1, 1,0,16'd4,  0,2'd1,16'h5555, 0,0};
        tbl[6]  = '{1,1,16'd1,    1, 0,1,16'd1,  0,2'd1,16'h5555, 0,0};
        tbl[7]  = '{1,1,16'd0,    1, 0,0,16'd1,  0,2'd1,16'h5555, 1,0};
        tbl[8]  = '{1,1,16'd7,    1, 1,0,16'd7,  0,2'd1,16'h5555, 0,0};
        tbl[9]  = '{1,1,16'd2,    1, 0,1,16'd2,  0,2'd1,16'h5555, 0,0};
        tbl[10] = '{1,1,16'd0,    1, 0,0,16'd2,  0,2'd1,16'h5555, 1,0};
        tbl[11] = '{1,0,16'h3333, 0, 0,0,16'd2,  0,2'd1,16'h5555, 0,0};
        tbl[12] = '{0,1,16'd9,    0, 0,0,16'd2,  0,2'd1,16'h5555, 0,0};
        tbl[13] = '{0,1,16'd9,    0, 0,0,16'd2,  0,2'd1,16'h5555, 0,0};

        do_reset();

        // Basic packet, zero-weight packets, empty FIFO and stall gating
        for (int i = 0; i < 14; i++) begin
            npu_state_config      = tbl[i].cfg;
            npu_config_fifo_empty = !tbl[i].has;
            npu_config_fifo_dout  = tbl[i].dout;
            #1;
            chk("tbl_read_en", {63'd0, npu_config_fifo_read_en}, {63'd0, tbl[i].rd});
            @(posedge CLK);
            #1;
            chk($sformatf("tbl_vec%0d", i), outs(),
                pack(tbl[i].in_en, tbl[i].out_en, tbl[i].data_in, tbl[i].wr_en,
                     tbl[i].wr_addr, tbl[i].wr_data, tbl[i].done, tbl[i].err));
        end

        // Split packet across a config-state exit
        do_reset();
        fifo.push_back(16'd4); fifo.push_back(16'd1);
        repeat (3) step(1'b1);
        repeat (5) step(1'b0);
        fifo.push_back(16'd1); fifo.push_back(16'h1234);
        fifo.push_back(16'd99);
        repeat (5) step(1'b0);
        chk("split_frozen", {62'd0, npu_state_output_reg_enable, weight_wr_en}, 64'd0);
        step(1'b1);
        chk("split_wcnt_nowrite", {63'd0, weight_wr_en}, 64'd0);
        step(1'b1);
        chk("split_write", {weight_wr_en, weight_wr_addr, weight_wr_data, config_done},
            {1'b1, 2'd0, 16'h1234, 1'b1});
        step(1'b1);
        chk("split_resync", {npu_state_input_reg_enable, npu_state_data_in}, {1'b1, 16'd99});
        fifo.push_back(16'd0); fifo.push_back(16'd0);
        repeat (3) step(1'b1);

        // Overflow: six weights into a four-word memory
        fifo.push_back(16'd11); fifo.push_back(16'd12); fifo.push_back(16'd6);
        for (int i = 1; i <= 6; i++) fifo.push_back(16'(i));
        repeat (7) step(1'b1);
        chk("ovf_last_write", {weight_wr_en, weight_wr_addr, weight_wr_data, config_error},
            {1'b1, 2'd3, 16'd4, 1'b0});
        step(1'b1);
        chk("ovf_error_rise", {weight_wr_en, config_error}, {1'b0, 1'b1});
        step(1'b1);
        chk("ovf_done", {weight_wr_en, config_done, config_error}, {1'b0, 1'b1, 1'b1});
        repeat (3) step(1'b1);
        chk("ovf_sticky", {63'd0, config_error}, 64'd1);

        // Reset mid-packet
        fifo.push_back(16'd9); fifo.push_back(16'd2);
        repeat (2) step(1'b1);
        do_reset();
        chk("rst_all_zero", outs(), 64'd0);
        fifo.push_back(16'd8); fifo.push_back(16'd1); fifo.push_back(16'd0);
        step(1'b1);
        chk("rst_fresh_in", {npu_state_input_reg_enable, npu_state_data_in}, {1'b1, 16'd8});
        repeat (3) step(1'b1);

        // Randomized packet streams with random config and FIFO arrival
        for (int c = 0; c < 2000; c++) begin
            if (pending.size() == 0) begin
                int n;
                n = $urandom_range(0, 7);
                pending.push_back(16'($urandom));
                pending.push_back(16'($urandom));
                pending.push_back(16'(n));
                for (int j = 0; j < n; j++) pending.push_back(16'($urandom));
            end
            if ($urandom_range(0, 3) != 0) fifo.push_back(pending.pop_front());
            step($urandom_range(0, 9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
